multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit.
// A Moore FSM steps each instruction through fetch, decode, execute,
// memory and writeback. Outputs are decoded from the registered state;
// the only input-dependent outputs are pc_en in BEQ (from zero) and
// alu_op in RTEX (from funct). The sticky illegal flag records any
// unsupported opcode or funct until the next reset.
module multicycle_control #(
  parameter int ENABLE_ADDI = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEX   = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam bit ADDI_ON = (ENABLE_ADDI != 0);

  state_t cur_state;
  logic [2:0] rtype_op;
  logic rtype_ok;

  assign state = cur_state;

  // Translate the R-type funct field into an ALU operation and flag unknown ones
  always_comb begin
    rtype_op = ALU_ADD;
    rtype_ok = 1'b1;
    case (funct)
      6'b100000: rtype_op = ALU_ADD;
      6'b100010: rtype_op = ALU_SUB;
      6'b100100: rtype_op = ALU_AND;
      6'b100101: rtype_op = ALU_OR;
      6'b101010: rtype_op = ALU_SLT;
      default: begin
        rtype_op = ALU_ADD;
        rtype_ok = 1'b0;
      end
    endcase
  end

  // State sequencing and sticky illegal flag; opcode/funct only matter in DECODE, MEMADR and RTEX
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= FETCH;
      illegal   <= 1'b0;
    end else begin
      case (cur_state)
        FETCH: cur_state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: cur_state <= MEMADR;
            OP_RTYPE:     cur_state <= RTEX;
            OP_BEQ:       cur_state <= BEQ;
            OP_J:         cur_state <= JUMP;
            OP_ADDI: begin
              if (ADDI_ON) begin
                cur_state <= ADDIEX;
              end else begin
                cur_state <= FETCH;
                illegal   <= 1'b1;
              end
            end
            default: begin
              cur_state <= FETCH;
              illegal   <= 1'b1;
            end
          endcase
        end
        MEMADR: begin
          if (opcode == OP_SW) cur_state <= MEMWR;
          else if (opcode == OP_LW) cur_state <= MEMRD;
          else cur_state <= FETCH;
        end
        MEMRD:  cur_state <= MEMWB;
        RTEX: begin
          if (rtype_ok) begin
            cur_state <= ALUWB;
          end else begin
            cur_state <= FETCH;
            illegal   <= 1'b1;
          end
        end
        ADDIEX: cur_state <= ADDIWB;
        default: cur_state <= FETCH;
      endcase
    end
  end

  // Per-state control outputs; anything not driven in a state stays 0 with an ADD ALU op
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    alu_op     = ALU_ADD;
    case (cur_state)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_en     = 1'b1;
      end
      DECODE: alu_src_b = 2'b11;
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      RTEX: begin
        alu_src_a = 1'b1;
        alu_op    = rtype_op;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ADDIWB: reg_write = 1'b1;
      BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = 2'b01;
        pc_en     = zero;
      end
      JUMP: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// Two instances share inputs: dut with addi enabled, dut_na with it disabled.
// Control outputs are packed as
// {pc_en,iord,mem_read,mem_write,ir_write,reg_write,reg_dst,mem_to_reg,
//  alu_src_a,alu_src_b[1:0],pc_source[1:0],alu_op[2:0]}.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic zero = 1'b0;

  logic pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic illegal;

  logic na_pc_en, na_iord, na_mem_read, na_mem_write, na_ir_write, na_reg_write, na_reg_dst;
  logic na_mem_to_reg, na_alu_src_a;
  logic [1:0] na_alu_src_b, na_pc_source;
  logic [2:0] na_alu_op;
  logic [3:0] na_state;
  logic na_illegal;

  logic [15:0] outs;
  assign outs = {pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                 alu_src_a, alu_src_b, pc_source, alu_op};

  int pass_count = 0;
  int check_count = 0;

  multicycle_control #(.ENABLE_ADDI(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op),
    .state(state), .illegal(illegal)
  );

  multicycle_control #(.ENABLE_ADDI(0)) dut_na (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(na_pc_en), .iord(na_iord), .mem_read(na_mem_read), .mem_write(na_mem_write),
    .ir_write(na_ir_write), .reg_write(na_reg_write), .reg_dst(na_reg_dst),
    .mem_to_reg(na_mem_to_reg), .alu_src_a(na_alu_src_a), .alu_src_b(na_alu_src_b),
    .pc_source(na_pc_source), .alu_op(na_alu_op), .state(na_state), .illegal(na_illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    check_count++;
    if (state !== 4'd0) $display("[TB] FAIL reset_state got %0d expected 0", state);
    else pass_count++;
    check_count++;
    if (illegal !== 1'b0) $display("[TB] FAIL reset_illegal got %0b expected 0", illegal);
    else pass_count++;
    check_count++;
    if (outs !== 16'hA822) $display("[TB] FAIL reset_outs got %h expected A822", outs);
    else pass_count++;
    check_count++;
    if (na_state !== 4'd0) $display("[TB] FAIL reset_na_state got %0d expected 0", na_state);
    else pass_count++;
  endtask

  // lw, with opcode corrupted during MEMRD to show it is ignored there
  task automatic test_lw();
    logic [3:0] es [6];
    logic [15:0] eo [6];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    eo = '{16'hA822, 16'h0062, 16'h00C2, 16'h6002, 16'h0502, 16'hA822};
    apply_reset();
    opcode = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      check_count++;
      if (state !== es[i]) $display("[TB] FAIL lw_state[%0d] got %0d expected %0d", i, state, es[i]);
      else pass_count++;
      check_count++;
      if (outs !== eo[i]) $display("[TB] FAIL lw_outs[%0d] got %h expected %h", i, outs, eo[i]);
      else pass_count++;
      if (i == 3) opcode = 6'b111111;
      if (i < 5) step();
    end
    check_count++;
    if (illegal !== 1'b0) $display("[TB] FAIL lw_illegal got %0b expected 0", illegal);
    else pass_count++;
  endtask

  task automatic test_sw();
    logic [3:0] es [5];
    logic [15:0] eo [5];
    es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    eo = '{16'hA822, 16'h0062, 16'h00C2, 16'h5002, 16'hA822};
    apply_reset();
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      check_count++;
      if (state !== es[i]) $display("[TB] FAIL sw_state[%0d] got %0d expected %0d", i, state, es[i]);
      else pass_count++;
      check_count++;
      if (outs !== eo[i]) $display("[TB] FAIL sw_outs[%0d] got %h expected %h", i, outs, eo[i]);
      else pass_count++;
      if (i < 4) step();
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [5];
    logic [2:0] op [5];
    logic [3:0] es [5];
    logic [15:0] eo [5];
    fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    op = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    es = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    for (int k = 0; k < 5; k++) begin
      eo = '{16'hA822, 16'h0062, {13'h0010, op[k]}, 16'h0602, 16'hA822};
      apply_reset();
      opcode = 6'b000000;
      funct = fn[k];
      for (int i = 0; i < 5; i++) begin
        check_count++;
        if (state !== es[i]) $display("[TB] FAIL rtype%0d_state[%0d] got %0d expected %0d", k, i, state, es[i]);
        else pass_count++;
        check_count++;
        if (outs !== eo[i]) $display("[TB] FAIL rtype%0d_outs[%0d] got %h expected %h", k, i, outs, eo[i]);
        else pass_count++;
        if (i == 3) funct = 6'b000111;
        if (i < 4) step();
      end
      check_count++;
      if (illegal !== 1'b0) $display("[TB] FAIL rtype%0d_illegal got %0b expected 0", k, illegal);
      else pass_count++;
    end
  endtask

  task automatic test_bad_funct();
    logic [3:0] es [4];
    logic [15:0] eo [4];
    es = '{4'd0, 4'd1, 4'd6, 4'd0};
    eo = '{16'hA822, 16'h0062, 16'h0082, 16'hA822};
    apply_reset();
    opcode = 6'b000000;
    funct = 6'b000111;
    for (int i = 0; i < 4; i++) begin
      check_count++;
      if (state !== es[i]) $display("[TB] FAIL badfunct_state[%0d] got %0d expected %0d", i, state, es[i]);
      else pass_count++;
      check_count++;
      if (outs !== eo[i]) $display("[TB] FAIL badfunct_outs[%0d] got %h expected %h", i, outs, eo[i]);
      else pass_count++;
      if (i < 3) step();
    end
    check_count++;
    if (illegal !== 1'b1) $display("[TB] FAIL badfunct_illegal got %0b expected 1", illegal);
    else pass_count++;
  endtask

  task automatic test_beq();
    logic [3:0] es [4];
    logic [15:0] eo [4];
    es = '{4'd0, 4'd1, 4'd8, 4'd0};
    for (int z = 1; z >= 0; z--) begin
      eo = '{16'hA822, 16'h0062, (z == 1) ? 16'h808E : 16'h008E, 16'hA822};
      apply_reset();
      opcode = 6'b000100;
      zero = (z == 1);
      for (int i = 0; i < 4; i++) begin
        check_count++;
        if (state !== es[i]) $display("[TB] FAIL beq_z%0d_state[%0d] got %0d expected %0d", z, i, state, es[i]);
        else pass_count++;
        check_count++;
        if (outs !== eo[i]) $display("[TB] FAIL beq_z%0d_outs[%0d] got %h expected %h", z, i, outs, eo[i]);
        else pass_count++;
        if (i < 3) step();
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [3:0] es [4];
    logic [15:0] eo [4];
    es = '{4'd0, 4'd1, 4'd11, 4'd0};
    eo = '{16'hA822, 16'h0062, 16'h8012, 16'hA822};
    apply_reset();
    opcode = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      check_count++;
      if (state !== es[i]) $display("[TB] FAIL jump_state[%0d] got %0d expected %0d", i, state, es[i]);
      else pass_count++;
      check_count++;
      if (outs !== eo[i]) $display("[TB] FAIL jump_outs[%0d] got %h expected %h", i, outs, eo[i]);
      else pass_count++;
      if (i < 3) step();
    end
  endtask

  // Illegal opcode is sticky across a following legal instruction and clears only on reset
  task automatic test_illegal_opcode();
    logic [3:0] es [3];
    logic [15:0] eo [3];
    es = '{4'd0, 4'd1, 4'd0};
    eo = '{16'hA822, 16'h0062, 16'hA822};
    apply_reset();
    opcode = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      check_count++;
      if (state !== es[i]) $display("[TB] FAIL illop_state[%0d] got %0d expected %0d", i, state, es[i]);
      else pass_count++;
      check_count++;
      if (outs !== eo[i]) $display("[TB] FAIL illop_outs[%0d] got %h expected %h", i, outs, eo[i]);
      else pass_count++;
      check_count++;
      if (illegal !== (i == 2)) $display("[TB] FAIL illop_illegal[%0d] got %0b expected %0b", i, illegal, (i == 2));
      else pass_count++;
      if (i < 2) step();
    end
    opcode = 6'b000000;
    funct = 6'b100000;
    repeat (4) step();
    check_count++;
    if (state !== 4'd0 || illegal !== 1'b1)
      $display("[TB] FAIL illop_sticky got state %0d illegal %0b expected state 0 illegal 1", state, illegal);
    else pass_count++;
    apply_reset();
    check_count++;
    if (illegal !== 1'b0) $display("[TB] FAIL illop_clear got %0b expected 0", illegal);
    else pass_count++;
  endtask

  task automatic test_reset_memwr();
    apply_reset();
    opcode = 6'b111111;
    step();
    step();
    opcode = 6'b101011;
    step();
    step();
    step();
    check_count++;
    if (state !== 4'd5 || mem_write !== 1'b1 || illegal !== 1'b1)
      $display("[TB] FAIL memwr_pre got state %0d mem_write %0b illegal %0b expected 5 1 1", state, mem_write, illegal);
    else pass_count++;
    apply_reset();
    check_count++;
    if (state !== 4'd0) $display("[TB] FAIL memwr_rst_state got %0d expected 0", state);
    else pass_count++;
    check_count++;
    if (mem_write !== 1'b0 || reg_write !== 1'b0)
      $display("[TB] FAIL memwr_rst_writes got mw %0b rw %0b expected 0 0", mem_write, reg_write);
    else pass_count++;
    check_count++;
    if (illegal !== 1'b0) $display("[TB] FAIL memwr_rst_illegal got %0b expected 0", illegal);
    else pass_count++;
  endtask

  task automatic test_addi();
    logic [3:0] es [5];
    logic [15:0] eo [5];
    logic [3:0] ns [5];
    es = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
    eo = '{16'hA822, 16'h0062, 16'h00C2, 16'h0402, 16'hA822};
    ns = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd2};
    apply_reset();
    opcode = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      check_count++;
      if (state !== es[i]) $display("[TB] FAIL addi_state[%0d] got %0d expected %0d", i, state, es[i]);
      else pass_count++;
      check_count++;
      if (outs !== eo[i]) $display("[TB] FAIL addi_outs[%0d] got %h expected %h", i, outs, eo[i]);
      else pass_count++;
      if (i < 3) begin
        check_count++;
        if (na_state !== ns[i]) $display("[TB] FAIL addi_na_state[%0d] got %0d expected %0d", i, na_state, ns[i]);
        else pass_count++;
      end
      check_count++;
      if (na_reg_write !== 1'b0) $display("[TB] FAIL addi_na_regwrite[%0d] got %0b expected 0", i, na_reg_write);
      else pass_count++;
      if (i < 4) step();
    end
    check_count++;
    if (na_illegal !== 1'b1) $display("[TB] FAIL addi_na_illegal got %0b expected 1", na_illegal);
    else pass_count++;
    check_count++;
    if (illegal !== 1'b0) $display("[TB] FAIL addi_illegal got %0b expected 0", illegal);
    else pass_count++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_bad_funct();
    test_beq();
    test_jump();
    test_illegal_opcode();
    test_reset_memwr();
    test_addi();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
